// File: rtl/exec_unit_sync.sv
// Multi-cycle command executor: accepts one decoded command per valid/ready
// handshake and runs it through IDLE -> EXEC -> (MRD) -> WB.
module exec_unit_sync #(
    parameter int WORD_SIZE_ = 32,
    parameter int ADDR_SIZE_ = 32,
    parameter int WORDS_NUM_ = 4096,
    parameter int REGS_NUM_  = 32
) (
    input  logic                    CLK_,
    input  logic                    RST_,
    input  logic                    CMD_VALID_,
    input  logic [3:0]              CMD_OP_,
    input  logic [3*WORD_SIZE_-1:0] CMD_ARG_,
    output logic                    READY_FL_,
    output logic                    DONE_FL_,
    output logic                    JMP_FL_,
    output logic [ADDR_SIZE_-1:0]   NEW_EXEC_ADDR_OFF_,
    output logic                    ERR_FL_
);
    localparam int RIDX_W = (REGS_NUM_ > 1) ? $clog2(REGS_NUM_) : 1;
    localparam int MADR_W = (WORDS_NUM_ > 1) ? $clog2(WORDS_NUM_) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0, ST_EXEC = 2'd1, ST_MRD = 2'd2, ST_WB = 2'd3;
    localparam logic [3:0] OP_NOP = 4'd0, OP_MOV = 4'd1, OP_ADD = 4'd2, OP_SUB = 4'd3,
                           OP_CMP = 4'd4, OP_JMP = 4'd5, OP_JEQ = 4'd6, OP_JGG = 4'd7,
                           OP_JLL = 4'd8;

    logic [1:0]              state_r;
    logic [3:0]              op_r;
    logic [3*WORD_SIZE_-1:0] arg_r;
    logic [WORD_SIZE_-1:0]   regs_r [REGS_NUM_];
    logic [WORD_SIZE_-1:0]   mem_r  [WORDS_NUM_];
    logic                    eq_r, gg_r, ll_r;
    logic                    ready_r, done_r, jmp_r, err_r;
    logic [ADDR_SIZE_-1:0]   off_r;
    logic                    reg_we_r, mem_we_r, flags_we_r, from_mem_r;
    logic [RIDX_W-1:0]       wr_idx_r;
    logic [MADR_W-1:0]       rd_addr_r, wr_addr_r;
    logic [WORD_SIZE_-1:0]   result_r, rdata_r;
    logic [2:0]              cmp_r;

    logic [7:0]            reg_a_s, reg_b_s, reg_c_s;
    logic                  wr_num_s, wr_mem_s, rd_num_s, rd_mem_s;
    logic [WORD_SIZE_-1:0] wnum_s, rnum_s, val_a_s, val_b_s, val_c_s, wb_data_s;
    logic                  err_s, reg_we_s, mem_we_s, flags_we_s, taken_s, to_mrd_s;
    logic [WORD_SIZE_-1:0] result_s, rd_addr_s, wr_addr_s;
    logic [2:0]            cmp_s;
    logic                  unused_s;

    function automatic logic bad_reg(input logic [7:0] id);
        return (32'(id) >= 32'(REGS_NUM_));
    endfunction

    function automatic logic bad_addr(input logic [WORD_SIZE_-1:0] addr);
        return (64'(addr) >= 64'(WORDS_NUM_));
    endfunction

    assign reg_a_s  = arg_r[7:0];
    assign reg_b_s  = arg_r[15:8];
    assign reg_c_s  = arg_r[23:16];
    assign wr_num_s = arg_r[24];
    assign wr_mem_s = arg_r[25];
    assign rd_num_s = arg_r[26];
    assign rd_mem_s = arg_r[27];
    assign wnum_s   = arg_r[2*WORD_SIZE_-1:WORD_SIZE_];
    assign rnum_s   = arg_r[3*WORD_SIZE_-1:2*WORD_SIZE_];
    assign unused_s = ^arg_r[31:28];

    // Out-of-range ids alias onto real registers here; such commands are flagged and never write.
    assign val_a_s   = regs_r[reg_a_s[RIDX_W-1:0]];
    assign val_b_s   = regs_r[reg_b_s[RIDX_W-1:0]];
    assign val_c_s   = regs_r[reg_c_s[RIDX_W-1:0]];
    assign wb_data_s = from_mem_r ? rdata_r : result_r;

    // Operand decode, result/address computation and error detection for the captured command
    always_comb begin
        err_s      = 1'b0;
        reg_we_s   = 1'b0;
        mem_we_s   = 1'b0;
        flags_we_s = 1'b0;
        taken_s    = 1'b0;
        to_mrd_s   = 1'b0;
        result_s   = '0;
        rd_addr_s  = '0;
        wr_addr_s  = '0;
        cmp_s      = 3'b000;
        case (op_r)
            OP_NOP: err_s = 1'b0;
            OP_MOV: begin
                // The non-memory source value doubles as the memory read address.
                rd_addr_s = rd_num_s ? rnum_s : val_b_s;
                wr_addr_s = wr_num_s ? wnum_s : val_a_s;
                result_s  = rd_addr_s;
                to_mrd_s  = rd_mem_s;
                mem_we_s  = wr_mem_s;
                reg_we_s  = !wr_mem_s;
                err_s     = (!rd_num_s && bad_reg(reg_b_s)) ||
                            (!(wr_mem_s && wr_num_s) && bad_reg(reg_a_s)) ||
                            (rd_mem_s && bad_addr(rd_addr_s)) ||
                            (wr_mem_s && bad_addr(wr_addr_s));
            end
            OP_ADD: begin
                result_s = val_b_s + val_c_s;
                reg_we_s = 1'b1;
                err_s    = bad_reg(reg_a_s) || bad_reg(reg_b_s) || bad_reg(reg_c_s);
            end
            OP_SUB: begin
                result_s = val_b_s - val_c_s;
                reg_we_s = 1'b1;
                err_s    = bad_reg(reg_a_s) || bad_reg(reg_b_s) || bad_reg(reg_c_s);
            end
            OP_CMP: begin
                flags_we_s = 1'b1;
                cmp_s      = {val_b_s == val_c_s, val_b_s > val_c_s, val_b_s < val_c_s};
                err_s      = bad_reg(reg_b_s) || bad_reg(reg_c_s);
            end
            OP_JMP:  taken_s = 1'b1;
            OP_JEQ:  taken_s = eq_r;
            OP_JGG:  taken_s = gg_r;
            OP_JLL:  taken_s = ll_r;
            default: err_s = 1'b1;
        endcase
    end

    // Control FSM, register file, compare flags and status pulses
    always_ff @(posedge CLK_) begin
        if (RST_) begin
            state_r    <= ST_IDLE;
            ready_r    <= 1'b1;
            done_r     <= 1'b0;
            jmp_r      <= 1'b0;
            err_r      <= 1'b0;
            off_r      <= '0;
            {eq_r, gg_r, ll_r} <= 3'b000;
            op_r       <= OP_NOP;
            arg_r      <= '0;
            reg_we_r   <= 1'b0;
            mem_we_r   <= 1'b0;
            flags_we_r <= 1'b0;
            from_mem_r <= 1'b0;
            wr_idx_r   <= '0;
            rd_addr_r  <= '0;
            wr_addr_r  <= '0;
            result_r   <= '0;
            cmp_r      <= 3'b000;
            for (int i = 0; i < REGS_NUM_; i++) regs_r[i] <= '0;
        end else begin
            done_r <= 1'b0;
            jmp_r  <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (CMD_VALID_) begin
                        op_r    <= CMD_OP_;
                        arg_r   <= CMD_ARG_;
                        ready_r <= 1'b0;
                        state_r <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    reg_we_r   <= reg_we_s && !err_s;
                    mem_we_r   <= mem_we_s && !err_s;
                    flags_we_r <= flags_we_s && !err_s;
                    from_mem_r <= to_mrd_s && !err_s;
                    wr_idx_r   <= reg_a_s[RIDX_W-1:0];
                    rd_addr_r  <= rd_addr_s[MADR_W-1:0];
                    wr_addr_r  <= wr_addr_s[MADR_W-1:0];
                    result_r   <= result_s;
                    cmp_r      <= cmp_s;
                    if (to_mrd_s && !err_s) begin
                        state_r <= ST_MRD;
                    end else begin
                        // Status is presented during WB so the fetch stage sees it before READY returns.
                        state_r <= ST_WB;
                        done_r  <= 1'b1;
                        err_r   <= err_s;
                        jmp_r   <= taken_s && !err_s;
                        if (taken_s && !err_s) off_r <= ADDR_SIZE_'(rnum_s);
                    end
                end
                ST_MRD: begin
                    state_r <= ST_WB;
                    done_r  <= 1'b1;
                end
                ST_WB: begin
                    if (reg_we_r) regs_r[wr_idx_r] <= wb_data_s;
                    if (flags_we_r) {eq_r, gg_r, ll_r} <= cmp_r;
                    state_r <= ST_IDLE;
                    ready_r <= 1'b1;
                end
                default: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    // Data RAM: contents survive reset, but a reset edge suppresses any pending write
    always_ff @(posedge CLK_) begin
        if (!RST_ && state_r == ST_WB && mem_we_r) mem_r[wr_addr_r] <= wb_data_s;
        if (state_r == ST_MRD) rdata_r <= mem_r[rd_addr_r];
    end

    assign READY_FL_          = ready_r;
    assign DONE_FL_           = done_r;
    assign JMP_FL_            = jmp_r;
    assign ERR_FL_            = err_r;
    assign NEW_EXEC_ADDR_OFF_ = off_r;
endmodule

// File: tb/tb_exec_unit_sync.sv
// Self-checking bench for exec_unit_sync: directed scenarios plus random
// commands compared against an architectural reference model.
module tb_exec_unit_sync;
    logic        clk_s, rst_s, valid_s, ready_s, done_s, jmp_s, err_s;
    logic [3:0]  op_s;
    logic [95:0] arg_s;
    logic [31:0] off_s;

    int n_tests = 0;
    int n_fail  = 0;
    int acc_cnt = 0;
    int done_cnt = 0;

    logic [31:0] m_regs [0:31];
    logic [31:0] m_mem  [0:4095];
    bit          m_vld  [0:4095];
    bit          m_eq, m_gg, m_ll;
    logic [31:0] m_off;

    exec_unit_sync dut (
        .CLK_(clk_s), .RST_(rst_s), .CMD_VALID_(valid_s), .CMD_OP_(op_s), .CMD_ARG_(arg_s),
        .READY_FL_(ready_s), .DONE_FL_(done_s), .JMP_FL_(jmp_s),
        .NEW_EXEC_ADDR_OFF_(off_s), .ERR_FL_(err_s)
    );

    initial clk_s = 1'b0;
    always #5 clk_s = ~clk_s;

    // Count handshakes and completion pulses for the throughput scenario
    always @(posedge clk_s) begin
        if (!rst_s && valid_s && ready_s) acc_cnt++;
        if (done_s) done_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [95:0] mk_arg(input int a, input int b, input int c,
                                           input bit wn, input bit wm, input bit rn, input bit rm,
                                           input logic [31:0] wnum, input logic [31:0] rnum);
        logic [95:0] v;
        v = '0;
        v[7:0] = 8'(a); v[15:8] = 8'(b); v[23:16] = 8'(c);
        v[24] = wn; v[25] = wm; v[26] = rn; v[27] = rm;
        v[63:32] = wnum; v[95:64] = rnum;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_eq = 1'b0; m_gg = 1'b0; m_ll = 1'b0;
        m_off = 32'd0;
    endtask

    // Architectural effect of one command; returns expected status and latency
    task automatic model(input logic [3:0] op, input logic [95:0] arg,
                         output bit e_err, output bit e_jmp, output int e_lat);
        int a, b, c;
        bit wn, wm, rn, rm;
        logic [31:0] wnum, rnum, sa, da, src;
        a = int'(arg[7:0]); b = int'(arg[15:8]); c = int'(arg[23:16]);
        wn = arg[24]; wm = arg[25]; rn = arg[26]; rm = arg[27];
        wnum = arg[63:32]; rnum = arg[95:64];
        e_err = 1'b0; e_jmp = 1'b0; e_lat = 2;
        case (op)
            4'd0: e_err = 1'b0;
            4'd1: begin
                if (!rn && b >= 32) e_err = 1'b1;
                if (!(wm && wn) && a >= 32) e_err = 1'b1;
                if (!e_err) begin
                    sa = rn ? rnum : m_regs[b];
                    da = wn ? wnum : m_regs[a];
                    if (rm && sa >= 32'd4096) e_err = 1'b1;
                    if (wm && da >= 32'd4096) e_err = 1'b1;
                    if (!e_err) begin
                        src = rm ? m_mem[sa[11:0]] : sa;
                        if (wm) begin m_mem[da[11:0]] = src; m_vld[da[11:0]] = 1'b1; end
                        else m_regs[a] = src;
                        if (rm) e_lat = 3;
                    end
                end
            end
            4'd2, 4'd3: begin
                if (a >= 32 || b >= 32 || c >= 32) e_err = 1'b1;
                else m_regs[a] = (op == 4'd2) ? m_regs[b] + m_regs[c] : m_regs[b] - m_regs[c];
            end
            4'd4: begin
                if (b >= 32 || c >= 32) e_err = 1'b1;
                else begin
                    m_eq = (m_regs[b] == m_regs[c]);
                    m_gg = (m_regs[b] > m_regs[c]);
                    m_ll = (m_regs[b] < m_regs[c]);
                end
            end
            4'd5, 4'd6, 4'd7, 4'd8: begin
                e_jmp = (op == 4'd5) || (op == 4'd6 && m_eq) || (op == 4'd7 && m_gg) || (op == 4'd8 && m_ll);
                if (e_jmp) m_off = rnum;
            end
            default: e_err = 1'b1;
        endcase
    endtask

    // Issue one command at a negedge, track latency/status, return at the negedge READY is back
    task automatic exec_cmd(input logic [3:0] op, input logic [95:0] arg, input bit hold);
        int k, n, e_lat;
        bit e_err, e_jmp;
        model(op, arg, e_err, e_jmp, e_lat);
        op_s = op; arg_s = arg; valid_s = 1'b1;
        k = 0;
        while (!ready_s && k < 20) begin @(negedge clk_s); k++; end
        chk("accept_wait", 64'(k), 64'd0);
        @(posedge clk_s);
        @(negedge clk_s);
        op_s = 4'($urandom); arg_s = {$urandom, $urandom, $urandom}; valid_s = hold;
        n = 0;
        while (!done_s && n < 10) begin @(negedge clk_s); n++; end
        chk("latency", 64'(n + 1), 64'(e_lat));
        chk("ready_busy", 64'(ready_s), 64'd0);
        chk("err_fl", 64'(err_s), 64'(e_err));
        chk("jmp_fl", 64'(jmp_s), 64'(e_jmp));
        chk("offset", 64'(off_s), 64'(m_off));
        @(negedge clk_s);
        chk("done_pulse", 64'(done_s), 64'd0);
        chk("ready_back", 64'(ready_s), 64'd1);
    endtask

    task automatic do_reset();
        rst_s = 1'b1; valid_s = 1'b0;
        repeat (2) @(negedge clk_s);
        rst_s = 1'b0;
        model_reset();
    endtask

    initial begin
        int a, b, c, r, a0, d0;
        bit wn, wm, rn, rm, hold;
        logic [3:0] op;
        logic [31:0] wnum, rnum;
        rst_s = 1'b1; valid_s = 1'b0; op_s = 4'd0; arg_s = '0;
        for (int i = 0; i < 4096; i++) begin m_mem[i] = 32'd0; m_vld[i] = 1'b0; end
        do_reset();
        chk("rst_ready", 64'(ready_s), 64'd1);
        chk("rst_done", 64'(done_s), 64'd0);
        chk("rst_jmp", 64'(jmp_s), 64'd0);
        chk("rst_err", 64'(err_s), 64'd0);
        chk("rst_off", 64'(off_s), 64'd0);

        // Moves through registers and memory
        exec_cmd(4'd1, mk_arg(3, 0, 0, 0, 0, 1, 0, 0, 32'hDEADBEEF), 1'b0);
        chk("mov_num", 64'(dut.regs_r[3]), 64'h0DEADBEEF);
        exec_cmd(4'd1, mk_arg(5, 3, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        exec_cmd(4'd1, mk_arg(0, 5, 0, 1, 1, 0, 0, 32'h10, 0), 1'b0);
        exec_cmd(4'd1, mk_arg(7, 0, 0, 0, 0, 1, 1, 0, 32'h10), 1'b0);
        chk("mov_mem", 64'(dut.regs_r[7]), 64'h0DEADBEEF);

        // Arithmetic wraparound, then compare and jumps
        exec_cmd(4'd1, mk_arg(1, 0, 0, 0, 0, 1, 0, 0, 32'hFFFFFFFF), 1'b0);
        exec_cmd(4'd1, mk_arg(2, 0, 0, 0, 0, 1, 0, 0, 32'd2), 1'b0);
        exec_cmd(4'd2, mk_arg(3, 1, 2, 0, 0, 0, 0, 0, 0), 1'b0);
        chk("add_wrap", 64'(dut.regs_r[3]), 64'd1);
        exec_cmd(4'd3, mk_arg(4, 2, 1, 0, 0, 0, 0, 0, 0), 1'b0);
        chk("sub_wrap", 64'(dut.regs_r[4]), 64'd3);
        exec_cmd(4'd4, mk_arg(0, 1, 2, 0, 0, 0, 0, 0, 0), 1'b0);
        exec_cmd(4'd2, mk_arg(8, 1, 1, 0, 0, 0, 0, 0, 0), 1'b0);
        exec_cmd(4'd7, mk_arg(0, 0, 0, 0, 0, 0, 0, 0, 32'h40), 1'b0);
        chk("jgg_off", 64'(off_s), 64'h40);
        exec_cmd(4'd6, mk_arg(0, 0, 0, 0, 0, 0, 0, 0, 32'h80), 1'b0);
        chk("jeq_off", 64'(off_s), 64'h40);
        exec_cmd(4'd8, mk_arg(0, 0, 0, 0, 0, 0, 0, 0, 32'h90), 1'b0);
        exec_cmd(4'd5, mk_arg(0, 0, 0, 0, 0, 0, 0, 0, 32'h123), 1'b0);

        // Error cases leave state untouched
        exec_cmd(4'd1, mk_arg(0, 1, 0, 1, 1, 0, 0, 32'd4096, 0), 1'b0);
        exec_cmd(4'd12, mk_arg(1, 2, 3, 0, 0, 0, 0, 0, 0), 1'b0);
        exec_cmd(4'd2, mk_arg(40, 1, 2, 0, 0, 0, 0, 0, 0), 1'b0);
        exec_cmd(4'd0, mk_arg(0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        // Same register read and written
        exec_cmd(4'd2, mk_arg(1, 1, 2, 0, 0, 0, 0, 0, 0), 1'b0);
        chk("add_self", 64'(dut.regs_r[1]), 64'd1);

        // VALID held high across four back-to-back commands
        a0 = acc_cnt; d0 = done_cnt;
        exec_cmd(4'd1, mk_arg(10, 0, 0, 0, 0, 1, 0, 0, 32'h11), 1'b1);
        exec_cmd(4'd2, mk_arg(11, 10, 10, 0, 0, 0, 0, 0, 0), 1'b1);
        exec_cmd(4'd1, mk_arg(0, 11, 0, 1, 1, 0, 0, 32'h20, 0), 1'b1);
        exec_cmd(4'd1, mk_arg(12, 0, 0, 0, 0, 1, 1, 0, 32'h20), 1'b1);
        valid_s = 1'b0;
        chk("hold_accepts", 64'(acc_cnt - a0), 64'd4);
        chk("hold_dones", 64'(done_cnt - d0), 64'd4);
        chk("hold_result", 64'(dut.regs_r[12]), 64'h22);

        // Reset while a memory-read MOV sits in MRD
        d0 = done_cnt;
        op_s = 4'd1; arg_s = mk_arg(9, 0, 0, 0, 0, 1, 1, 0, 32'h10); valid_s = 1'b1;
        @(posedge clk_s);
        @(negedge clk_s);
        valid_s = 1'b0;
        @(negedge clk_s);
        rst_s = 1'b1;
        @(negedge clk_s);
        rst_s = 1'b0;
        model_reset();
        chk("abort_done", 64'(done_cnt - d0), 64'd0);
        chk("abort_ready", 64'(ready_s), 64'd1);
        chk("abort_reg", 64'(dut.regs_r[9]), 64'd0);
        chk("abort_off", 64'(off_s), 64'd0);

        // Known memory window, then random commands
        for (int i = 0; i < 16; i++)
            exec_cmd(4'd1, mk_arg(0, 0, 0, 1, 1, 1, 0, 32'(i), $urandom), 1'b0);
        for (int t = 0; t < 300; t++) begin
            r = $urandom_range(0, 18);
            if (r <= 9) op = 4'd1;
            else if (r <= 16) op = 4'(r - 8);
            else if (r == 17) op = 4'd0;
            else op = 4'($urandom_range(9, 15));
            a = $urandom_range(0, 35); b = $urandom_range(0, 35); c = $urandom_range(0, 35);
            wn = 1'($urandom); wm = 1'($urandom); rn = 1'($urandom); rm = 1'($urandom);
            r = $urandom_range(0, 3);
            rnum = (r == 0) ? $urandom : (r == 1) ? 32'(4096 + $urandom_range(0, 99)) : 32'($urandom_range(0, 15));
            wnum = ($urandom_range(0, 4) == 0) ? 32'(4096 + $urandom_range(0, 99)) : 32'($urandom_range(0, 15));
            // Never read RAM words whose contents the model cannot know
            if (op == 4'd1 && rm && !rn && b < 32 && m_regs[b] < 32'd4096 && !m_vld[m_regs[b][11:0]]) rn = 1'b1;
            if (op == 4'd1 && rm && rn && rnum < 32'd4096 && !m_vld[rnum[11:0]]) rnum = 32'($urandom_range(0, 15));
            hold = ($urandom_range(0, 3) == 0);
            exec_cmd(op, mk_arg(a, b, c, wn, wm, rn, rm, wnum, rnum), hold);
            if (a < 32) chk("rand_reg", 64'(dut.regs_r[a]), 64'(m_regs[a]));
        end
        valid_s = 1'b0;
        for (int i = 0; i < 32; i++) chk("final_reg", 64'(dut.regs_r[i]), 64'(m_regs[i]));
        for (int i = 0; i < 17; i++) chk("final_mem", 64'(dut.mem_r[i]), 64'(m_mem[i]));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
